// File: rtl/port_uart_tx.sv
// 8N1 UART serialiser for the CPU output port: any change of the port value sends
// the whole word, MSB byte first. Changes that arrive mid-frame are coalesced.
module port_uart_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int BAUD_DIV   = 434
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] port_data,
  output logic                  tx,
  output logic                  busy,
  output logic                  overrun
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int CW     = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] last_q, last_d;
  logic [DATA_WIDTH-1:0] prev_q, prev_d;
  logic [BW-1:0]         byte_idx_q, byte_idx_d;
  logic [2:0]            bit_idx_q, bit_idx_d;
  logic [CW-1:0]         baud_q, baud_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  overrun_q, overrun_d;

  logic [DATA_WIDTH-1:0] shifted_s;
  logic [7:0]            cur_byte_s;
  logic                  baud_last_s;

  // Current byte is selected by shifting the latched word left so it sits at the top
  always_comb begin
    shifted_s   = shift_q << {byte_idx_q, 3'b000};
    cur_byte_s  = shifted_s[DATA_WIDTH-1 -: 8];
    baud_last_s = (baud_q == BAUD_LAST);
  end

  // Next-state logic; tx_d is the line level for the cycle after this edge
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    last_d     = last_q;
    prev_d     = port_data;
    byte_idx_d = byte_idx_q;
    bit_idx_d  = bit_idx_q;
    baud_d     = baud_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    overrun_d  = overrun_q | (busy_q & (port_data != prev_q));
    case (state_q)
      IDLE: begin
        if (port_data != last_q) begin
          shift_d    = port_data;
          last_d     = port_data;
          byte_idx_d = {BW{1'b0}};
          bit_idx_d  = 3'd0;
          baud_d     = {CW{1'b0}};
          state_d    = START;
          busy_d     = 1'b1;
          tx_d       = 1'b0;
        end else begin
          tx_d   = 1'b1;
          busy_d = 1'b0;
        end
      end
      START: begin
        if (baud_last_s) begin
          baud_d    = {CW{1'b0}};
          bit_idx_d = 3'd0;
          tx_d      = cur_byte_s[0];
          state_d   = DATA;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      DATA: begin
        if (baud_last_s) begin
          baud_d = {CW{1'b0}};
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = cur_byte_s[bit_idx_q + 3'd1];
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      STOP: begin
        if (baud_last_s) begin
          baud_d = {CW{1'b0}};
          if (byte_idx_q != BYTE_LAST) begin
            byte_idx_d = byte_idx_q + BW'(1);
            tx_d       = 1'b0;
            state_d    = START;
          end else begin
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset idles the line high and forgets the last value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= {DATA_WIDTH{1'b0}};
      last_q     <= {DATA_WIDTH{1'b0}};
      prev_q     <= {DATA_WIDTH{1'b0}};
      byte_idx_q <= {BW{1'b0}};
      bit_idx_q  <= 3'd0;
      baud_q     <= {CW{1'b0}};
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      last_q     <= last_d;
      prev_q     <= prev_d;
      byte_idx_q <= byte_idx_d;
      bit_idx_q  <= bit_idx_d;
      baud_q     <= baud_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_port_uart_tx.sv
// Bench for port_uart_tx: stimulus queues expected bytes, a line monitor decodes
// the UART output and checks each byte against the queue.
module tb_port_uart_tx;

  localparam int DW = 32;
  localparam int BD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] port_data;
  logic          tx;
  logic          busy;
  logic          overrun;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  port_uart_tx #(.DATA_WIDTH(DW), .BAUD_DIV(BD)) dut (
    .clk       (clk),
    .reset     (reset),
    .port_data (port_data),
    .tx        (tx),
    .busy      (busy),
    .overrun   (overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
  endtask

  // Caller has just driven a new port value after a posedge
  task automatic expect_start(input string name);
    @(negedge clk);
    check({name, "_pre_tx"}, 32'(tx), 32'd1);
    @(negedge clk);
    check({name, "_tx_low"}, 32'(tx), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd1);
  endtask

  // Counts busy negedges, starting at 1 for the one the caller already saw
  task automatic measure_busy(output int n);
    bit done;
    n = 1;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (busy === 1'b1) begin
        n++;
        if (n > 2000) done = 1'b1;
      end else begin
        done = 1'b1;
      end
    end
  endtask

  task automatic wait_neg(input int n, inout bit ab);
    repeat (n) begin
      if (!ab) begin
        @(negedge clk);
        if (reset === 1'b1) ab = 1'b1;
      end
    end
  endtask

  // Line monitor: samples each bit mid-cell and scores completed bytes
  initial begin : monitor
    logic [7:0] data;
    logic       stop_bit;
    bit         aborted;
    data = 8'h00;
    stop_bit = 1'b0;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && tx === 1'b0) begin
        aborted = 1'b0;
        wait_neg(1, aborted);
        for (int i = 0; i < 8 && !aborted; i++) begin
          wait_neg(BD, aborted);
          data[i] = tx;
        end
        if (!aborted) begin
          wait_neg(BD, aborted);
          stop_bit = tx;
        end
        if (!aborted) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_byte: got %02h expected none", data);
          end else begin
            check("byte", 32'(data), 32'(exp_q.pop_front()));
            check("stop_bit", 32'(stop_bit), 32'd1);
          end
        end
      end
    end
  end

  initial begin : stimulus
    int n;
    int bad;
    reset = 1'b1;
    port_data = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Zero equals the reset last-sent value: nothing may go out
    bad = 0;
    repeat (500) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || overrun !== 1'b0) bad++;
    end
    check("t1_idle_bad_cycles", 32'(bad), 32'd0);

    push_word(32'h0000_0001);
    @(posedge clk); #1 port_data = 32'h0000_0001;
    expect_start("t2");
    measure_busy(n);
    check("t2_busy_cycles", 32'(n), 32'd160);
    check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

    push_word(32'hA5C3_0F81);
    @(posedge clk); #1 port_data = 32'hA5C3_0F81;
    expect_start("t3");
    measure_busy(n);
    check("t3_busy_cycles", 32'(n), 32'd160);
    check("t3_queue_empty", 32'(exp_q.size()), 32'd0);
    check("t3_overrun", 32'(overrun), 32'd0);

    // Mid-frame changes: 2 is lost, 3 follows after one idle cycle
    push_word(32'h0000_0011);
    push_word(32'h0000_0003);
    @(posedge clk); #1 port_data = 32'h0000_0011;
    expect_start("t4a");
    repeat (20) @(posedge clk);
    #1 port_data = 32'h0000_0002;
    @(negedge clk);
    check("t4_overrun_pre", 32'(overrun), 32'd0);
    @(negedge clk);
    check("t4_overrun_set", 32'(overrun), 32'd1);
    repeat (10) @(posedge clk);
    #1 port_data = 32'h0000_0003;
    measure_busy(n);
    check("t4a_no_timeout", 32'(n < 2000), 32'd1);
    @(negedge clk);
    check("t4_gap_busy", 32'(busy), 32'd1);
    check("t4_gap_tx", 32'(tx), 32'd0);
    measure_busy(n);
    check("t4b_busy_cycles", 32'(n), 32'd160);
    check("t4_overrun_sticky", 32'(overrun), 32'd1);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (busy !== 1'b0) bad++;
    end
    check("t4_no_third_frame", 32'(bad), 32'd0);
    check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset during byte 1 (all zeros) of a frame; only byte 0 completes
    exp_q.push_back(8'h01);
    @(posedge clk); #1 port_data = 32'h0100_0000;
    expect_start("t5a");
    repeat (50) @(negedge clk);
    check("t5_mid_tx_low", 32'(tx), 32'd0);
    #1 reset = 1'b1;
    #1;
    check("t5_async_tx", 32'(tx), 32'd1);
    check("t5_async_busy", 32'(busy), 32'd0);
    check("t5_async_overrun", 32'(overrun), 32'd0);
    port_data = 32'h0000_0007;
    repeat (5) @(negedge clk);
    check("t5_queue_after_abort", 32'(exp_q.size()), 32'd0);
    push_word(32'h0000_0007);
    @(posedge clk); #1 reset = 1'b0;
    expect_start("t5b");
    measure_busy(n);
    check("t5b_busy_cycles", 32'(n), 32'd160);
    check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

    // Rewriting the same value must not send anything
    @(posedge clk); #1 port_data = 32'h0000_0007;
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx !== 1'b1) bad++;
    end
    check("t6_no_frame", 32'(bad), 32'd0);
    check("t6_overrun", 32'(overrun), 32'd0);
    check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
